// File: rtl/monitor_pkg.sv
// Shared constants for the serial monitor: host opcodes, response bytes,
// the FSM state encoding and the address-byte helper.
package monitor_pkg;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_DUMP   = 8'h02;
    localparam logic [7:0] OP_EXEC   = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // State codes are visible on the LED port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_HDR      = 4'd1,
        ST_DISPATCH = 4'd2,
        ST_LOAD     = 4'd3,
        ST_DUMP_RD  = 4'd4,
        ST_DUMP_WT  = 4'd5,
        ST_DUMP_TX  = 4'd6,
        ST_CSUM     = 4'd7,
        ST_RUN      = 4'd8,
        ST_STAT     = 4'd9,
        ST_NAK      = 4'd10
    } state_t;

    // Number of address bytes in a frame header for a given RAM address width.
    function automatic int addr_bytes(input int addr_w);
        return (addr_w <= 8) ? 1 : 2;
    endfunction

endpackage

// File: rtl/uart_monitor_if.sv
// Bundle of the UART, RAM and CPU-control signals owned by the monitor.
// master = monitor side, slave = UART/RAM/CPU environment side.
interface uart_monitor_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]        rx_byte;
    logic              received;
    logic [7:0]        tx_byte;
    logic              transmit;
    logic              is_transmitting;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        din;
    logic              write_en;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        dout;
    logic              cpu_reset;
    logic              cpu_run;
    logic              cpu_halted;
    logic [3:0]        state;
    logic [7:0]        err_cnt;

    modport master (
        input  rx_byte, received, is_transmitting, dout, cpu_halted,
        output tx_byte, transmit, waddr, din, write_en, raddr,
               cpu_reset, cpu_run, state, err_cnt
    );

    modport slave (
        output rx_byte, received, is_transmitting, dout, cpu_halted,
        input  tx_byte, transmit, waddr, din, write_en, raddr,
               cpu_reset, cpu_run, state, err_cnt
    );
endinterface

// File: rtl/monitor_txq.sv
// Transmit path: one-entry holding register, a guard cycle after every
// transmit strobe, and the transmit strobe itself. The UART reports busy one
// cycle late, so a strobe is never issued back-to-back or in the guard cycle.
// A push while the register is full overwrites the pending byte.
module monitor_txq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_byte,
    input  logic       is_transmitting,
    output logic [7:0] tx_byte,
    output logic       transmit,
    output logic       full
);
    logic [7:0] hold_byte;
    logic       guard;
    logic       send;

    assign send = full && !is_transmitting && !transmit && !guard;

    // Holding register, guard cycle and registered strobe/byte to the UART.
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_byte <= 8'h00;
            full      <= 1'b0;
            guard     <= 1'b0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            transmit <= send;
            guard    <= transmit;
            if (send) begin
                tx_byte <= hold_byte;
                full    <= 1'b0;
            end
            // A new byte in the same cycle as a send refills the register.
            if (push) begin
                hold_byte <= push_byte;
                full      <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_monitor.sv
// Serial monitor: decodes LOAD / DUMP / EXEC / STATUS frames from the UART,
// owns the RAM ports while the CPU is stopped, and hands UART/RAM to the CPU
// during EXEC until it halts. Optional trailing checksum on LOAD and DUMP is
// enabled by defining UART_MONITOR_CHECKSUM_EN.
module uart_monitor
    import monitor_pkg::*;
#(
    parameter int          ADDR_W  = 9,
    parameter logic [23:0] TIMEOUT = 24'd1_200_000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_monitor_if.master bus
);
    localparam int ADDR_BYTES = addr_bytes(ADDR_W);

`ifdef UART_MONITOR_CHECKSUM_EN
    localparam state_t DONE_ST = ST_CSUM;
`else
    localparam state_t DONE_ST = ST_IDLE;
`endif

    state_t            st;
    logic [1:0]        hdr_cnt;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [7:0]        csum;
    logic [23:0]       timer;
    logic [7:0]        dump_data;
    logic              push_q;
    logic [7:0]        push_byte_q;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        din;
    logic              write_en;
    logic [ADDR_W-1:0] raddr;
    logic              cpu_reset;
    logic              cpu_run;
    logic [7:0]        err_cnt;
    logic              txq_full;

    logic tx_free;
    logic timed_out;
    logic err_inc;
    logic err_clr;

    // Tx availability, receive-gap expiry and error-counter events.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        tx_free   = !txq_full && !push_q;
        timed_out = 1'b0;
        err_inc   = 1'b0;
        err_clr   = 1'b0;
        if (TIMEOUT != 24'd0 && timer == TIMEOUT - 24'd1 && !bus.received &&
            (st == ST_HDR || st == ST_LOAD))
            timed_out = 1'b1;
        if (timed_out || (st == ST_NAK && tx_free))
            err_inc = 1'b1;
        if (st == ST_STAT && tx_free)
            err_clr = 1'b1;
    end

    // Saturating error counter; a STATUS clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'h00;
        else if (err_clr)
            err_cnt <= 8'h00;
        else if (err_inc && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    // Frame decoder and command sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= ST_IDLE;
            hdr_cnt     <= 2'd0;
            opcode      <= 8'h00;
            addr        <= '0;
            len         <= 8'h00;
            csum        <= 8'h00;
            timer       <= 24'd0;
            dump_data   <= 8'h00;
            push_q      <= 1'b0;
            push_byte_q <= 8'h00;
            waddr       <= '0;
            din         <= 8'h00;
            write_en    <= 1'b0;
            raddr       <= '0;
            cpu_reset   <= 1'b0;
            cpu_run     <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            write_en  <= 1'b0;
            cpu_reset <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (bus.received) begin
                        opcode      <= bus.rx_byte;
                        push_q      <= 1'b1;
                        push_byte_q <= bus.rx_byte;
                        hdr_cnt     <= 2'd0;
                        addr        <= '0;
                        timer       <= 24'd0;
                        st          <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (bus.received) begin
                        push_q      <= 1'b1;
                        push_byte_q <= bus.rx_byte;
                        timer       <= 24'd0;
                        if (hdr_cnt == 2'(ADDR_BYTES)) begin
                            len <= bus.rx_byte;
                            st  <= ST_DISPATCH;
                        end else begin
                            // Shift in MSB first; bits above ADDR_W fall off.
                            addr    <= ADDR_W'({16'(addr), bus.rx_byte});
                            hdr_cnt <= hdr_cnt + 2'd1;
                        end
                    end else if (timed_out) begin
                        st <= ST_IDLE;
                    end else begin
                        timer <= timer + 24'd1;
                    end
                end
                ST_DISPATCH: begin
                    csum  <= 8'h00;
                    timer <= 24'd0;
                    raddr <= addr;
                    case (opcode)
                        OP_LOAD:   st <= (len == 8'd0) ? DONE_ST : ST_LOAD;
                        OP_DUMP:   st <= (len == 8'd0) ? DONE_ST : ST_DUMP_RD;
                        OP_EXEC: begin
                            cpu_reset <= 1'b1;
                            cpu_run   <= 1'b1;
                            st        <= ST_RUN;
                        end
                        OP_STATUS: st <= ST_STAT;
                        default:   st <= ST_NAK;
                    endcase
                end
                ST_LOAD: begin
                    if (bus.received) begin
                        write_en    <= 1'b1;
                        din         <= bus.rx_byte;
                        waddr       <= addr;
                        addr        <= addr + ADDR_W'(1);
                        csum        <= csum + bus.rx_byte;
                        len         <= len - 8'd1;
                        push_q      <= 1'b1;
                        push_byte_q <= bus.rx_byte;
                        timer       <= 24'd0;
                        if (len == 8'd1)
                            st <= DONE_ST;
                    end else if (timed_out) begin
                        st <= ST_IDLE;
                    end else begin
                        timer <= timer + 24'd1;
                    end
                end
                // raddr is already stable here; the RAM samples it this cycle.
                ST_DUMP_RD: st <= ST_DUMP_WT;
                ST_DUMP_WT: begin
                    dump_data <= bus.dout;
                    st        <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (tx_free) begin
                        push_q      <= 1'b1;
                        push_byte_q <= dump_data;
                        csum        <= csum + dump_data;
                        len         <= len - 8'd1;
                        raddr       <= raddr + ADDR_W'(1);
                        st          <= (len == 8'd1) ? DONE_ST : ST_DUMP_RD;
                    end
                end
                ST_CSUM: begin
                    if (tx_free) begin
                        push_q      <= 1'b1;
                        push_byte_q <= csum;
                        st          <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The halt level seen during the reset pulse is stale.
                    if (!cpu_reset && bus.cpu_halted && tx_free) begin
                        cpu_run     <= 1'b0;
                        push_q      <= 1'b1;
                        push_byte_q <= ACK;
                        st          <= ST_IDLE;
                    end
                end
                ST_STAT: begin
                    if (tx_free) begin
                        push_q      <= 1'b1;
                        push_byte_q <= err_cnt;
                        st          <= ST_IDLE;
                    end
                end
                ST_NAK: begin
                    if (tx_free) begin
                        push_q      <= 1'b1;
                        push_byte_q <= NAK;
                        st          <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    monitor_txq u_txq (
        .clk             (clk),
        .rst_n           (rst_n),
        .push            (push_q),
        .push_byte       (push_byte_q),
        .is_transmitting (bus.is_transmitting),
        .tx_byte         (bus.tx_byte),
        .transmit        (bus.transmit),
        .full            (txq_full)
    );

    assign bus.waddr     = waddr;
    assign bus.din       = din;
    assign bus.write_en  = write_en;
    assign bus.raddr     = raddr;
    assign bus.cpu_reset = cpu_reset;
    assign bus.cpu_run   = cpu_run;
    assign bus.state     = st;
    assign bus.err_cnt   = err_cnt;
endmodule

// File: tb/tb_uart_monitor.sv
// Directed bench for uart_monitor: host frames in, UART/RAM models around the
// DUT, expected bytes queued at stimulus time and matched as they go out.
module tb_uart_monitor;
    localparam int          ADDR_W   = 9;
    localparam logic [23:0] TIMEOUT  = 24'd200;
    localparam int          BYTE_CYC = 20;
    localparam int          HOST_GAP = 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_monitor_if #(.ADDR_W(ADDR_W)) bus ();

    uart_monitor #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    bit [7:0]   got_mem [256];
    int         got_wr = 0;
    int         got_rd = 0;
    int         busy_tx_cnt = 0;
    int         creset_cnt = 0;
    int         creset_norun = 0;
    int         we_cnt = 0;

    bit uart_pend = 1'b0;
    bit uart_busy = 1'b0;
    int uart_left = 0;
    assign bus.is_transmitting = uart_busy;

    bit [7:0] mem [512] = '{default: 8'h00};

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.write_en === 1'b1)
            mem[bus.waddr] <= bus.din;
        bus.dout <= mem[bus.raddr];
    end

    // Output monitor plus UART model that reports busy one cycle late.
    always @(negedge clk) begin
        if (bus.transmit === 1'b1) begin
            if (bus.is_transmitting) busy_tx_cnt++;
            got_mem[got_wr % 256] = bus.tx_byte;
            got_wr++;
        end
        if (bus.cpu_reset === 1'b1) begin
            creset_cnt++;
            if (bus.cpu_run !== 1'b1) creset_norun++;
        end
        if (bus.write_en === 1'b1) we_cnt++;
        if (uart_pend) uart_left = BYTE_CYC;
        else if (uart_left > 0) uart_left--;
        uart_pend = (bus.transmit === 1'b1);
        uart_busy = (uart_left > 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit echo);
        if (echo) exp_q.push_back(b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        repeat (HOST_GAP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] ahi,
                              input logic [7:0] alo, input logic [7:0] n, input bit echo);
        send(op, echo);
        send(ahi, echo);
        send(alo, echo);
        send(n, echo);
    endtask

    // Match every queued expectation against transmitted bytes in order.
    task automatic expect_tx(input string tag);
        logic [7:0] e;
        int waited;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            waited = 0;
            while (got_rd >= got_wr && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (got_rd >= got_wr) begin
                n_cmp++;
                n_bad++;
                $error("FAIL %s_timeout: observed no byte expected %0h", tag, e);
            end else begin
                check(tag, 32'(got_mem[got_rd % 256]), 32'(e));
                got_rd++;
            end
        end
    endtask

    initial begin
        int waited;
        int c0;
        int base;
        rst_n          = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.received   = 1'b0;
        bus.cpu_halted = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_transmit", 32'(bus.transmit), 32'd0);
        check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // LOAD across the top of the address space.
        send_frame(8'h01, 8'h01, 8'hFE, 8'h03, 1'b1);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b1);
`ifdef UART_MONITOR_CHECKSUM_EN
        exp_q.push_back(8'h31);
`endif
        expect_tx("load_echo");
        check("ram_1fe", 32'(mem[9'h1FE]), 32'hAA);
        check("ram_1ff", 32'(mem[9'h1FF]), 32'hBB);
        check("ram_000", 32'(mem[9'h000]), 32'hCC);
        check("load_we_cycles", 32'(we_cnt), 32'd3);

        // DUMP the same bytes back.
        send_frame(8'h02, 8'h01, 8'hFE, 8'h03, 1'b1);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hBB);
        exp_q.push_back(8'hCC);
`ifdef UART_MONITOR_CHECKSUM_EN
        exp_q.push_back(8'h31);
`endif
        expect_tx("dump");

        // Zero-length LOAD completes at once with no data.
        send_frame(8'h01, 8'h00, 8'h10, 8'h00, 1'b1);
`ifdef UART_MONITOR_CHECKSUM_EN
        exp_q.push_back(8'h00);
`endif
        expect_tx("load_n0");
        check("load_n0_idle", 32'(bus.state), 32'd0);

        // EXEC, ignored byte during RUN, then halt.
        c0 = creset_cnt;
        send_frame(8'h03, 8'h00, 8'h00, 8'h00, 1'b1);
        expect_tx("exec_echo");
        check("exec_cpu_run", 32'(bus.cpu_run), 32'd1);
        check("exec_state_run", 32'(bus.state), 32'd8);
        check("exec_reset_pulse", 32'(creset_cnt - c0), 32'd1);
        check("exec_reset_with_run", 32'(creset_norun), 32'd0);
        send(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        bus.cpu_halted = 1'b1;
        waited = 0;
        while (bus.cpu_run === 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("halt_cpu_run", 32'(bus.cpu_run), 32'd0);
        exp_q.push_back(8'h06);
        expect_tx("halt_ack");
        bus.cpu_halted = 1'b0;

        // Unknown opcode, then a header abandoned until the timeout.
        send_frame(8'h7F, 8'h00, 8'h00, 8'h00, 1'b1);
        exp_q.push_back(8'h15);
        expect_tx("nak");
        send(8'h01, 1'b1);
        send(8'h00, 1'b1);
        repeat (int'(TIMEOUT)) @(negedge clk);
        check("timeout_idle", 32'(bus.state), 32'd0);
        check("timeout_err_cnt", 32'(bus.err_cnt), 32'd2);
        expect_tx("timeout_echo");

        // STATUS reports then clears the error count.
        send_frame(8'h04, 8'h00, 8'h00, 8'h00, 1'b1);
        exp_q.push_back(8'h02);
        expect_tx("status1");
        send_frame(8'h04, 8'h00, 8'h00, 8'h00, 1'b1);
        exp_q.push_back(8'h00);
        expect_tx("status2");
        check("status_cleared", 32'(bus.err_cnt), 32'd0);

        // Reset in the middle of a 10-byte DUMP.
        base = got_wr;
        send_frame(8'h02, 8'h00, 8'h00, 8'h0A, 1'b0);
        waited = 0;
        while (got_wr < base + 8 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("middump_progress", 32'(got_wr >= base + 8), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(bus.state), 32'd0);
        check("mid_rst_transmit", 32'(bus.transmit), 32'd0);
        check("mid_rst_raddr", 32'(bus.raddr), 32'd0);
        check("mid_rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        check("mid_rst_we", 32'(bus.write_en), 32'd0);
        check("mid_rst_waddr", 32'(bus.waddr), 32'd0);
        check("mid_rst_din", 32'(bus.din), 32'd0);
        check("mid_rst_cpu", 32'({bus.cpu_reset, bus.cpu_run}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        got_rd = got_wr;

        send_frame(8'h02, 8'h00, 8'h00, 8'h01, 1'b1);
        exp_q.push_back(8'hCC);
`ifdef UART_MONITOR_CHECKSUM_EN
        exp_q.push_back(8'hCC);
`endif
        expect_tx("fresh_dump");

        repeat (60) @(negedge clk);
        check("no_extra_tx", 32'(got_wr), 32'(got_rd));
        check("tx_while_busy", 32'(busy_tx_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_monitor.md
# uart_monitor

Parametrised successor of the board-level serial monitor. Sits between the osdvu `uart` core, the dual-port `ram` and the `cpu`, and owns both the UART and the RAM ports while the CPU is stopped. Decodes framed host commands: LOAD, DUMP, EXEC, STATUS. Adds:
- configurable address width;
- an explicit opcode byte;
- header timeout with error counting;
- CPU hand-back on halt;
- optional checksums.

## Interface
Parameters:
- `ADDR_W`, 9, RAM address width (1..16); `ADDR_BYTES` = 1 if `ADDR_W`<=8 else 2.
- `TIMEOUT`, 24'd1_200_000, receive-gap limit in clk cycles; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_byte` in 8: UART received byte.
- `received` in 1: one-cycle strobe, `rx_byte` valid.
- `tx_byte` out 8: byte to UART.
- `transmit` out 1: one-cycle send strobe.
- `is_transmitting` in 1: UART busy.
- `waddr` out `ADDR_W`, `din` out 8, `write_en` out 1: RAM write port.
- `raddr` out `ADDR_W`: RAM read address.
- `dout` in 8: RAM data, valid one cycle after `raddr`.
- `cpu_reset` out 1: one-cycle pulse at EXEC.
- `cpu_run` out 1: high while the CPU owns the UART and RAM; the top-level muxes select on it.
- `cpu_halted` in 1: CPU halt level.
- `state` out 4: current FSM state, for LEDs.
- `err_cnt` out 8: saturating error count.

## Operation
- Frame format: opcode, then `ADDR_BYTES` address bytes (MSB first), then a length byte N (0..255). Header bytes are echoed.
- Opcodes:
  - 0x01 LOAD: N data bytes written to addr, addr+1, …; each byte is echoed.
  - 0x02 DUMP: N bytes read from RAM and transmitted.
  - 0x03 EXEC: address and length are ignored.
  - 0x04 STATUS: transmits `err_cnt`, then clears it.
  - Any other opcode: after the full header, transmit 0x15 (NAK), `err_cnt`++.
- Address increments modulo 2^`ADDR_W`; high address bits beyond `ADDR_W` are dropped. N=0 completes immediately with no data.
- FSM states:
  - IDLE (0): waits for an opcode.
  - HDR (1): byte counter 0..`ADDR_BYTES`.
  - DISPATCH (2).
  - LOAD (3).
  - DUMP_RD (4): present `raddr`.
  - DUMP_WT (5): capture `dout`.
  - DUMP_TX (6): send when the tx path is free.
  - CSUM (7).
  - RUN (8).
  - STAT (9).
  - NAK (10).
- Tx path: a one-entry holding register plus a guard cycle after each `transmit`. The UART raises `is_transmitting` one cycle late, so `transmit` is never asserted while `is_transmitting`=1, during the guard cycle, or while the holding register is full.
  - An echo arriving with the holding register full overwrites the pending byte (host pacing violation).
  - DUMP/STATUS/NAK stall until the holding register is empty.
- EXEC: one-cycle `cpu_reset` pulse, `cpu_run`←1, then RUN. In RUN the monitor ignores `received`. On `cpu_halted`=1: `cpu_run`←0, transmit 0x06 (ACK), go to IDLE.
- Timeout: in HDR or LOAD, if no `received` for `TIMEOUT` consecutive cycles → IDLE, `err_cnt`++, nothing transmitted.
- `err_cnt` saturates at 0xFF. If an error increment and a STATUS clear coincide, the clear wins.

## Timing
- Reset values (asynchronous, any state, including mid-RUN):
  - FSM in IDLE; `state`=0.
  - `transmit`=0, `write_en`=0, `cpu_reset`=0, `cpu_run`=0, `err_cnt`=0.
  - `tx_byte`, `waddr`, `raddr`, `din` = 0; holding register empty.
- LOAD: `write_en` is high for exactly the cycle after each data `received`; `din` and `waddr` are registered in the same cycle.
- DUMP: `raddr` presented in DUMP_RD, `dout` captured in DUMP_WT; minimum 3 cycles per byte plus UART busy time.
- Echo `transmit` is issued no earlier than one cycle after its `received`.
- `cpu_reset` is high for exactly one cycle, in the same cycle `cpu_run` rises.
- `cpu_halted` is sampled one cycle after `cpu_run` rises; a halt already asserted at entry ends RUN on the next cycle.

## Configuration
- `UART_MONITOR_CHECKSUM_EN` defined:
  - LOAD and DUMP keep an 8-bit modulo-256 sum of the data bytes.
  - After the last byte the FSM enters CSUM and transmits the sum; this also happens for N=0, where the sum is 0x00.
- Undefined: CSUM is unreachable and no trailing byte is sent.

## Structure
- Package `monitor_pkg`:
  - opcode constants (`OP_LOAD`=0x01, `OP_DUMP`=0x02, `OP_EXEC`=0x03, `OP_STATUS`=0x04);
  - response bytes `ACK`=0x06, `NAK`=0x15;
  - the 4-bit state encoding.
- One sub-module, `monitor_txq`: holding register, guard-cycle logic and the `transmit` strobe generation.

## Test plan
- LOAD with `ADDR_W`=9: host sends 01 01 FE 03 AA BB CC.
  - RAM 0x1FE=AA, 0x1FF=BB, 0x000=CC (wrap).
  - Seven echoes returned.
  - With checksum enabled, a trailing 0x31 is sent.
- DUMP after that load: 02 01 FE 03 → header echo, then AA BB CC.
  - No `transmit` while `is_transmitting`=1 (assert).
- EXEC: 03 00 00 00.
  - `cpu_reset` 1-cycle pulse; `cpu_run`=1.
  - Bytes received during RUN are ignored.
  - `cpu_halted` raised 50 cycles later → `cpu_run`=0, ACK 0x06.
- Error path: opcode 0x7F with a full header → NAK 0x15. Then 01 00 followed by silence for `TIMEOUT`+1 cycles → IDLE.
  - STATUS (04 00 00 00) returns 0x02.
  - A second STATUS returns 0x00.
- Reset mid-DUMP (N=10, after 4 bytes):
  - all outputs at reset values immediately;
  - a fresh DUMP 02 00 00 01 returns RAM[0].
